// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: two-flop synchroniser, per-key debounce FSM,
// one-cycle press/release/long-press pulses and a per-key LED toggle.
module key_debounce_multi #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_evt,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] led
);

    localparam int                DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
    localparam logic [N_KEYS-1:0] IDLE_LVL = ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] key_s;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
    end

    // Synchroniser resets to the idle pin level so leaving reset never looks like a press.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign key_s = sync2_q ^ IDLE_LVL;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        state_t           state_q, state_d;
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        logic             key_state_q, key_state_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             led_q, led_d;
        logic             enter_pressed;
        logic             accept_release;

        always_comb begin
            state_d        = state_q;
            deb_cnt_d      = deb_cnt_q;
            key_state_d    = key_state_q;
            press_d        = 1'b0;
            release_d      = 1'b0;
            led_d          = led_q;
            enter_pressed  = 1'b0;
            accept_release = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (key_s[i]) begin
                        state_d   = PRESS_CHK;
                        deb_cnt_d = DEB_ONE;
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!key_s[i]) begin
                        state_d   = RELEASED;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d       = PRESSED;
                        deb_cnt_d     = '0;
                        key_state_d   = 1'b1;
                        press_d       = 1'b1;
                        led_d         = ~led_q;
                        enter_pressed = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (!key_s[i]) begin
                        state_d   = RELEASE_CHK;
                        deb_cnt_d = DEB_ONE;
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                RELEASE_CHK: begin
                    if (key_s[i]) begin
                        state_d   = PRESSED;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d        = RELEASED;
                        deb_cnt_d      = '0;
                        key_state_d    = 1'b0;
                        release_d      = 1'b1;
                        accept_release = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                    end
                end
                default: begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                state_q     <= RELEASED;
                deb_cnt_q   <= '0;
                key_state_q <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                led_q       <= 1'b0;
            end else begin
                state_q     <= state_d;
                deb_cnt_q   <= deb_cnt_d;
                key_state_q <= key_state_d;
                press_q     <= press_d;
                release_q   <= release_d;
                led_q       <= led_d;
            end
        end

        assign key_state[i]   = key_state_q;
        assign press[i]       = press_q;
        assign release_evt[i] = release_q;
        assign led[i]         = led_q;

        if (LONG_CYCLES > 0) begin : g_long
            localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
            localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

            logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
            logic              long_press_q, long_press_d;

            // An accepted release wins over a long press landing on the same edge.
            always_comb begin
                hold_cnt_d   = hold_cnt_q;
                long_press_d = 1'b0;
                if (enter_pressed) begin
                    hold_cnt_d = '0;
                end else if ((state_q == PRESSED || (state_q == RELEASE_CHK && !accept_release))
                             && hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d   = hold_cnt_q + HOLD_ONE;
                    long_press_d = (hold_cnt_q == HOLD_LAST);
                end
            end

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    hold_cnt_q   <= '0;
                    long_press_q <= 1'b0;
                end else begin
                    hold_cnt_q   <= hold_cnt_d;
                    long_press_q <= long_press_d;
                end
            end

            assign long_press[i] = long_press_q;
        end else begin : g_no_long
            assign long_press[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed event timings.
module tb_key_debounce_multi;

    localparam int N = 4;
    localparam int D = 16;
    localparam int L = 64;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] key_state, press, release_evt, long_press, led;

    key_debounce_multi #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .key(key), .key_state(key_state),
        .press(press), .release_evt(release_evt), .long_press(long_press), .led(led)
    );

    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit run_chk = 1'b0;

    // Model: a level is accepted once D consecutive synchronised samples disagree with it;
    // a long press is the press that is still accepted exactly L cycles after it was accepted.
    bit p1[N], p2[N], lvl[N], mled[N];
    int run[N], pe[N];
    logic [3:0] e_state, e_press, e_rel, e_long, e_led;

    int press_cnt[N], rel_cnt[N], long_cnt[N];
    int press_cyc[N], rel_cyc[N], long_cyc[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step();
        bit ks;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                p1[i] = 0; p2[i] = 0; lvl[i] = 0; mled[i] = 0; run[i] = 0;
            end else begin
                ks    = p2[i];
                p2[i] = p1[i];
                p1[i] = ~key[i];
                if (ks != lvl[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == D) begin
                    lvl[i] = ks;
                    run[i] = 0;
                    if (ks) begin
                        e_press[i] = 1'b1;
                        mled[i]    = ~mled[i];
                        pe[i]      = cyc;
                    end else begin
                        e_rel[i] = 1'b1;
                    end
                end
                if (lvl[i] && (cyc - pe[i] == L)) e_long[i] = 1'b1;
            end
            e_state[i] = lvl[i];
            e_led[i]   = mled[i];
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_cyc[i] = -1; rel_cyc[i] = -1; long_cyc[i] = -1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) pe[i] = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            model_step();
            if (run_chk) begin
                chk("outputs", {12'd0, key_state, press, release_evt, long_press, led},
                    {12'd0, e_state, e_press, e_rel, e_long, e_led});
                for (int i = 0; i < N; i++) begin
                    if (press[i] === 1'b1)       begin press_cnt[i]++; press_cyc[i] = cyc; end
                    if (release_evt[i] === 1'b1) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
                    if (long_press[i] === 1'b1)  begin long_cnt[i]++;  long_cyc[i]  = cyc; end
                end
            end
        end
    end

    initial begin
        int t0, t1;
        int rem[N];
        clear_mon();
        rst = 1'b1;
        key = 4'hF;
        tick(1);
        run_chk = 1'b1;
        tick(4);
        chk("reset_values", {12'd0, key_state, press, release_evt, long_press, led}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Clean press and release on key 0
        clear_mon();
        key[0] = 1'b0; t0 = cyc;
        tick(40);
        chk("k0_state_held", {31'd0, key_state[0]}, 32'd1);
        chk("k0_led", {28'd0, led}, 32'h1);
        key[0] = 1'b1; t1 = cyc;
        tick(30);
        chk("k0_press_cnt", press_cnt[0], 1);
        chk("k0_press_lat", press_cyc[0] - t0, 18);
        chk("k0_no_long", long_cnt[0], 0);
        chk("k0_rel_cnt", rel_cnt[0], 1);
        chk("k0_rel_lat", rel_cyc[0] - t1, 18);

        // Bouncing press on key 1
        clear_mon();
        for (int j = 0; j < 12; j++) begin
            key[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        key[1] = 1'b0; t0 = cyc;
        tick(40);
        chk("k1_press_cnt", press_cnt[1], 1);
        chk("k1_press_lat", press_cyc[1] - t0, 18);
        chk("k1_no_rel_yet", rel_cnt[1], 0);
        key[1] = 1'b1;
        tick(30);
        chk("k1_rel_cnt", rel_cnt[1], 1);

        // Glitches on key 2: 15 cycles rejected, 16 accepted
        clear_mon();
        key[2] = 1'b0; tick(15); key[2] = 1'b1;
        tick(30);
        chk("k2_glitch_press", press_cnt[2], 0);
        chk("k2_glitch_led", {31'd0, led[2]}, 32'd0);
        key[2] = 1'b0; tick(16); key[2] = 1'b1;
        tick(40);
        chk("k2_min_press", press_cnt[2], 1);
        chk("k2_min_rel", rel_cnt[2], 1);

        // Long press on key 3 with a short release bounce
        clear_mon();
        key[3] = 1'b0; t0 = cyc;
        tick(100);
        key[3] = 1'b1; tick(10);
        key[3] = 1'b0; tick(90);
        key[3] = 1'b1; t1 = cyc;
        tick(30);
        chk("k3_press_cnt", press_cnt[3], 1);
        chk("k3_press_lat", press_cyc[3] - t0, 18);
        chk("k3_long_cnt", long_cnt[3], 1);
        chk("k3_long_lat", long_cyc[3] - press_cyc[3], 64);
        chk("k3_rel_cnt", rel_cnt[3], 1);
        chk("k3_rel_lat", rel_cyc[3] - t1, 18);

        // Parallel press, then reset while held
        clear_mon();
        key[1:0] = 2'b00;
        tick(25);
        chk("par_press0", press_cnt[0], 1);
        chk("par_press1", press_cnt[1], 1);
        chk("par_same_cycle", press_cyc[0] - press_cyc[1], 0);
        chk("par_led", {28'd0, led}, 32'hC);
        rst = 1'b1;
        tick(1);
        chk("rst_outputs", {12'd0, key_state, press, release_evt, long_press, led}, 32'd0);
        key = 4'hF;
        tick(3);
        rst = 1'b0;
        tick(30);
        chk("rst_no_release", rel_cnt[0] + rel_cnt[1], 0);
        chk("rst_no_press", press_cnt[0] + press_cnt[1], 2);

        // Randomised traffic on all keys, with one mid-run reset
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 30);
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk);
            rst = (c >= 2000 && c < 2002);
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    key[i] = ~key[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120)
                                                         : $urandom_range(1, 20);
                end else begin
                    rem[i]--;
                end
            end
        end
        key = 4'hF;
        tick(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised N-channel push-button debouncer for 50 MHz board designs. It replaces the single-key debounce-to-LED block. Per key it adds a two-flop synchroniser, a debounced level, one-cycle press, release and long-press event pulses, and a per-key LED toggle. It sits between the raw key pins and the user logic and LED drivers.

## Interface
- N_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples needed to accept a level change (20 ms at 50 MHz). Legal range ≥ 2.
- LONG_CYCLES, 50_000_000: pressed duration that fires long_press (1 s at 50 MHz). 0 disables long-press. Otherwise it must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 means pin low = pressed; 0 means pin high = pressed.
- sys_clk  in  1  system clock, 50 MHz nominal; the only clock.
- rst  in  1  synchronous, active-high reset.
- key  in  N_KEYS  raw asynchronous key pins.
- key_state  out  N_KEYS  debounced level, 1 = pressed.
- press  out  N_KEYS  one-cycle pulse on accepted press.
- release  out  N_KEYS  one-cycle pulse on accepted release.
- long_press  out  N_KEYS  one-cycle pulse, at most once per press.
- led  out  N_KEYS  toggles on each accepted press.

## Operation
- Each channel is fully independent. There is no shared counter and no cross-channel priority.
- Synchroniser: two flops per key. key_s = synchronised pin, XOR-normalised so that 1 = pressed.
- Per-channel FSM with states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. The stability counter is deb_cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - RELEASED:
    - key_s=1 → PRESS_CHK, deb_cnt←1.
    - Otherwise stay, deb_cnt←0.
  - PRESS_CHK:
    - key_s=0 → RELEASED, deb_cnt←0.
    - key_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 → PRESSED. Registered effects: key_state←1, press pulse, led toggles, hold_cnt←0.
    - Otherwise deb_cnt++.
  - PRESSED:
    - key_s=0 → RELEASE_CHK, deb_cnt←1.
    - Otherwise deb_cnt←0.
  - RELEASE_CHK:
    - key_s=1 → PRESSED, deb_cnt←0.
    - key_s=0 and deb_cnt==DEBOUNCE_CYCLES-1 → RELEASED. Registered effects: key_state←0, release pulse.
    - Otherwise deb_cnt++.
- Long press:
  - hold_cnt counts every cycle in PRESSED and RELEASE_CHK and saturates at LONG_CYCLES.
  - Release bounce does not restart hold_cnt.
  - long_press pulses for one cycle when hold_cnt increments to LONG_CYCLES. Saturation guarantees a single pulse per press.
  - If the release is accepted first, no long_press fires.
  - hold_cnt clears on entry to PRESSED from PRESS_CHK.
  - If LONG_CYCLES=0, long_press is tied to 0 and no hold counter is built.
- Glitch rejection: any pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change and no event.
- press and release never assert in the same cycle on one channel. Different channels may pulse in the same cycle.

## Timing
- Reset values:
  - FSM in RELEASED; deb_cnt and hold_cnt at 0.
  - key_state, press, release, long_press, led all 0.
  - Synchroniser flops reset to the unpressed pin level (1 if ACTIVE_LOW), so releasing reset never creates a press.
- Press latency: the pin is pressed before sys_clk edge k and held. key_s is sampled pressed at edges k+2 … k+DEBOUNCE_CYCLES+1. key_state rises and press is high in the cycle after edge k+DEBOUNCE_CYCLES+1.
- Release latency is symmetric to press latency.
- long_press rises LONG_CYCLES cycles after press rises, provided the release has not yet been accepted.
- rst mid-operation overrides everything on the next edge. No release pulse is produced for a key that was pressed at reset.
- All outputs are registered; there is no combinational path from key.

## Test plan
Bench parameters: N_KEYS=4, DEBOUNCE_CYCLES=16, LONG_CYCLES=64, ACTIVE_LOW=1, 20 ns clock. Check the reset values after 5 rst cycles.
- Clean press on key[0]: low and held 40 cycles, then high. press[0] pulses exactly 18 edges after the fall. key_state[0]=1, led=4'b0001, no long_press. release[0] pulses 18 edges after the rise.
- Bounce: key[1] toggles every 5 cycles for 60 cycles, then stays low. Exactly one press[1], 18 edges after the final fall. No events during the bounce.
- Glitch: key[2] low for 15 cycles, then high. No outputs change. key[2] low for 16 cycles then high: one press[2], followed by release[2].
- Long press: key[3] held 200 cycles with a 10-cycle release bounce at cycle 100. One press[3]. One long_press[3], 64 cycles after press. One release[3] only after the final release.
- Parallel and reset:
  - key[0] and key[1] pressed on the same edge: press[0] and press[1] assert in the same cycle.
  - Assert rst while both are held: all outputs read 0 on the next edge and no release pulse follows.
  - Second press of key[0]: led[0] toggles back to 0.
